shift_cipher_decryption: RTL and testbench

Parametrised successor of the single-key Caesar decryptor. Decrypts a stream of D_WIDTH-bit characters using either a fixed shift (Caesar mode) or a cycling multi-character key (Vigenère mode). Subtraction wraps modulo an alphabet window; characters outside the window pass through unchanged. It sits in the decryption path between the input demux and the output mux, with the same valid/busy stream interface as the other decryptors.

---
 rtl/shift_cipher_decryption.sv | 129 ++++++++++++
 tb/tb_shift_cipher_decryption.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_cipher_decryption.sv
// rtl/shift_cipher_decryption.sv - Caesar/Vigenere stream decryptor with windowed modular subtraction
module shift_cipher_decryption #(
    parameter int D_WIDTH    = 8,
    parameter int KEY_CHARS  = 4,
    parameter int ALPHA_BASE = 8'h41,
    parameter int ALPHA_SIZE = 26
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [D_WIDTH-1:0]             data_i,
    input  logic                           valid_i,
    input  logic                           msg_start_i,
    input  logic                           mode_i,
    input  logic [D_WIDTH*KEY_CHARS-1:0]   key_i,
    input  logic [$clog2(KEY_CHARS):0]     key_len_i,
    input  logic                           key_load_i,
    output logic                           busy,
    output logic [D_WIDTH-1:0]             data_o,
    output logic                           valid_o
);
    localparam int LW = $clog2(KEY_CHARS) + 1;
    localparam int IW = (KEY_CHARS > 1) ? $clog2(KEY_CHARS) : 1;
    localparam int W1 = D_WIDTH + 1;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                         state_q, state_d;
    logic [IW-1:0]                  cnt_q;
    logic [IW-1:0]                  idx_q;
    logic                           mode_q, mode_sh_q;
    logic [LW-1:0]                  len_q, len_sh_q;
    logic [D_WIDTH*KEY_CHARS-1:0]   key_sh_q;
    logic [D_WIDTH-1:0]             shift_q [KEY_CHARS];

    logic                           load_start, load_last, accept;
    logic [LW-1:0]                  len_clamped;
    logic [D_WIDTH-1:0]             load_char, load_shift;
    logic                           in_win;
    logic [IW-1:0]                  eff_idx, idx_next;
    logic [LW-1:0]                  eff_plus;
    logic [D_WIDTH-1:0]             s;
    logic [W1-1:0]                  d_ext, r, s_ext, diff;
    logic [D_WIDTH-1:0]             out_char;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (key_load_i) state_d = LOAD;
            LOAD:    if (cnt_q == IW'(KEY_CHARS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q == LOAD);
    assign load_start = (state_q == IDLE) && key_load_i;
    assign load_last  = (state_q == LOAD) && (cnt_q == IW'(KEY_CHARS - 1));
    assign accept     = valid_i && (state_q == IDLE);

    always_comb begin
        len_clamped = key_len_i;
        if (key_len_i == '0)
            len_clamped = LW'(1);
        else if (key_len_i > LW'(KEY_CHARS))
            len_clamped = LW'(KEY_CHARS);
    end

    assign load_char  = key_sh_q[cnt_q*D_WIDTH +: D_WIDTH];
    assign load_shift = D_WIDTH'(W1'(load_char) % W1'(ALPHA_SIZE));

    // Windowed subtraction runs one bit wider than a character so no step can overflow.
    always_comb begin
        d_ext    = {1'b0, data_i};
        in_win   = (d_ext >= W1'(ALPHA_BASE)) && (d_ext <= W1'(ALPHA_BASE + ALPHA_SIZE - 1));
        eff_idx  = msg_start_i ? '0 : idx_q;
        s        = mode_q ? shift_q[eff_idx] : shift_q[0];
        s_ext    = {1'b0, s};
        r        = d_ext - W1'(ALPHA_BASE);
        diff     = (r >= s_ext) ? (r - s_ext) : (r - s_ext + W1'(ALPHA_SIZE));
        out_char = in_win ? D_WIDTH'(W1'(ALPHA_BASE) + diff) : data_i;
        eff_plus = LW'(eff_idx) + LW'(1);
        idx_next = (eff_plus >= len_q) ? '0 : IW'(eff_plus);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            mode_q    <= 1'b0;
            mode_sh_q <= 1'b0;
            len_q     <= LW'(1);
            len_sh_q  <= LW'(1);
            key_sh_q  <= '0;
            for (int i = 0; i < KEY_CHARS; i++) shift_q[i] <= '0;
        end else begin
            valid_o <= 1'b0;
            if (accept) begin
                data_o  <= out_char;
                valid_o <= 1'b1;
                if (mode_q) begin
                    if (in_win)           idx_q <= idx_next;
                    else if (msg_start_i) idx_q <= '0;
                end
            end
            if (load_start) begin
                mode_sh_q <= mode_i;
                len_sh_q  <= len_clamped;
                key_sh_q  <= key_i;
                cnt_q     <= '0;
            end
            if (state_q == LOAD) begin
                shift_q[cnt_q] <= load_shift;
                cnt_q          <= cnt_q + 1'b1;
            end
            // New mode and length only take effect once every shift slot is written.
            if (load_last) begin
                mode_q <= mode_sh_q;
                len_q  <= len_sh_q;
                idx_q  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_shift_cipher_decryption.sv
// tb/tb_shift_cipher_decryption.sv - scoreboard bench for shift_cipher_decryption
module tb_shift_cipher_decryption;
    localparam int D_WIDTH   = 8;
    localparam int KEY_CHARS = 4;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic [D_WIDTH-1:0]           data_i = '0;
    logic                         valid_i = 1'b0;
    logic                         msg_start_i = 1'b0;
    logic                         mode_i = 1'b0;
    logic [D_WIDTH*KEY_CHARS-1:0] key_i = '0;
    logic [$clog2(KEY_CHARS):0]   key_len_i = '0;
    logic                         key_load_i = 1'b0;
    logic                         busy;
    logic [D_WIDTH-1:0]           data_o;
    logic                         valid_o;

    shift_cipher_decryption #(
        .D_WIDTH(D_WIDTH), .KEY_CHARS(KEY_CHARS), .ALPHA_BASE(8'h41), .ALPHA_SIZE(26)
    ) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .msg_start_i(msg_start_i), .mode_i(mode_i), .key_i(key_i),
        .key_len_i(key_len_i), .key_load_i(key_load_i), .busy(busy),
        .data_o(data_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every valid_o pulse must match the oldest expectation, one cycle after issue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && valid_o) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_valid_o: got data_o=%0h expected no output", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e.data || cyc != e.cyc) begin
                        n_errors++;
                        $display("FAIL data_o: got %0h at cycle %0d expected %0h at cycle %0d",
                                 data_o, cyc, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic ms, input logic [7:0] exp_d);
        exp_t e;
        @(negedge clk);
        data_i      = d;
        msg_start_i = ms;
        valid_i     = 1'b1;
        e.data = exp_d;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        valid_i     = 1'b0;
        msg_start_i = 1'b0;
    endtask

    task automatic load_key(input logic m, input logic [31:0] k, input logic [2:0] len);
        int n_busy;
        int guard;
        @(negedge clk);
        mode_i     = m;
        key_i      = k;
        key_len_i  = len;
        key_load_i = 1'b1;
        @(negedge clk);
        key_load_i = 1'b0;
        n_busy = 0;
        guard  = 0;
        while (busy && guard < 20) begin
            n_busy++;
            guard++;
            @(negedge clk);
        end
        check("busy_cycles", n_busy, KEY_CHARS);
    endtask

    initial begin
        int n_busy;
        exp_t e;

        // Reset and identity behaviour
        rst = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_valid_o", valid_o, 0);
        check("rst_data_o", data_o, 0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h44, 1'b0, 8'h44);

        // Caesar shift 3
        load_key(1'b0, 32'h0000_0003, 3'd1);
        send(8'h44, 1'b0, 8'h41);
        send(8'h41, 1'b0, 8'h58);
        send(8'h7A, 1'b0, 8'h7A);

        // Vigenere {3,1,4,1}: "DBEBH" -> "AAAAE"
        load_key(1'b1, {8'd1, 8'd4, 8'd1, 8'd3}, 3'd4);
        send("D", 1'b1, "A");
        send("B", 1'b0, "A");
        send("E", 1'b0, "A");
        send("B", 1'b0, "A");
        send("H", 1'b0, "E");

        // Vigenere {1,2}: space passes through without advancing the index
        load_key(1'b1, {8'd0, 8'd0, 8'd2, 8'd1}, 3'd2);
        send("B", 1'b1, "A");
        send(" ", 1'b0, " ");
        send("D", 1'b1, "C");
        send("D", 1'b0, "B");

        // Load while valid: load-cycle char uses old key (idx 0, shift 1), busy drops the rest
        @(negedge clk);
        mode_i     = 1'b0;
        key_i      = 32'h0000_0005;
        key_len_i  = 3'd1;
        key_load_i = 1'b1;
        valid_i    = 1'b1;
        data_i     = "Z";
        e.data = "Y";
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        key_load_i = 1'b0;
        n_busy = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) n_busy++;
            @(negedge clk);
        end
        check("drop_busy_cycles", n_busy, 4);
        check("drop_busy_low", busy, 0);
        e.data = "U";
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        valid_i = 1'b0;

        // Key char 30 reduces to shift 4
        load_key(1'b0, 32'h0000_001E, 3'd1);
        send("E", 1'b0, "A");
        send("B", 1'b0, "X");

        // key_len 0 behaves as length 1: always shift[0]
        load_key(1'b1, {8'd0, 8'd0, 8'd7, 8'd2}, 3'd0);
        send("C", 1'b1, "A");
        send("C", 1'b0, "A");
        send("C", 1'b0, "A");

        // Asynchronous reset in the middle of a load
        @(negedge clk);
        key_i      = 32'h0000_0005;
        mode_i     = 1'b0;
        key_len_i  = 3'd1;
        key_load_i = 1'b1;
        @(negedge clk);
        key_load_i = 1'b0;
        check("midload_busy_high", busy, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midload_rst_busy", busy, 0);
        check("midload_rst_valid_o", valid_o, 0);
        check("midload_rst_data_o", data_o, 0);
        @(negedge clk);
        rst = 1'b0;
        send("C", 1'b0, "C");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end
endmodule
